rgb2gray_stream: RTL and testbench

//  Streaming, parametrised RGB->grayscale converter for the image path.
//  - Accepts one RGB pixel per beat over valid/ready; emits weighted gray = (WR*R + WG*G + WB*B) >> SHIFT.
//  - Frame-aware: counts a ROWS x COLS frame, flags end-of-line/end-of-frame, raises done.
//  - Sits between the pixel source (file/DMA reader) and downstream filters.

---
 rtl/rgb2gray_pkg.sv | 36 +++
 rtl/rgb2gray_stream_if.sv | 29 ++
 rtl/rgb2gray_wsum.sv | 33 +++
 rtl/rgb2gray_stream.sv | 153 +++++++++++++++
 tb/tb_rgb2gray_stream.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb2gray_pkg.sv
// Shared constants and helpers for the streaming RGB->gray converter.
package rgb2gray_pkg;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_ROWS  = 1153;
    localparam int unsigned DEF_COLS  = 2048;
    localparam int unsigned DEF_WR    = 2;
    localparam int unsigned DEF_WG    = 5;
    localparam int unsigned DEF_WB    = 1;
    localparam int unsigned DEF_SHIFT = 3;

    // Converter control states
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Ceiling log2, valid for elaboration-time constants
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    // Width that holds WR*R + WG*G + WB*B without overflow
    function automatic int unsigned sum_width(input int unsigned pix_w,
                                              input int unsigned wr,
                                              input int unsigned wg,
                                              input int unsigned wb);
        return pix_w + clog2(wr + wg + wb + 1);
    endfunction

endpackage

// File: rtl/rgb2gray_stream_if.sv
// Pixel-in / gray-out stream bundle for rgb2gray_stream.
interface rgb2gray_stream_if
    import rgb2gray_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W
);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_red;
    logic [PIX_W-1:0] s_green;
    logic [PIX_W-1:0] s_blue;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_gray;
    logic             m_eol;
    logic             m_eof;

    // Environment side: drives pixels and downstream ready
    modport master (
        output s_valid, s_red, s_green, s_blue, m_ready,
        input  s_ready, m_valid, m_gray, m_eol, m_eof
    );

    // Converter side
    modport slave (
        input  s_valid, s_red, s_green, s_blue, m_ready,
        output s_ready, m_valid, m_gray, m_eol, m_eof
    );
endinterface

// File: rtl/rgb2gray_wsum.sv
// Stage 1: registered weighted channel sum with pipeline enable.
module rgb2gray_wsum #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned WR    = 2,
    parameter int unsigned WG    = 5,
    parameter int unsigned WB    = 1,
    parameter int unsigned SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_vld,
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    output logic [SUM_W-1:0] sum_q,
    output logic             vld_q
);

    // Load the weighted sum whenever the pipeline advances
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            sum_q <= '0;
        end else if (en) begin
            vld_q <= in_vld;
            sum_q <= SUM_W'(WR) * SUM_W'(red)
                   + SUM_W'(WG) * SUM_W'(green)
                   + SUM_W'(WB) * SUM_W'(blue);
        end
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// Frame-aware streaming RGB->grayscale converter.
// Optional build macro GRAY_ROUND_EN: round-half-up before the shift
// (default build truncates).
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned WR    = DEF_WR,
    parameter int unsigned WG    = DEF_WG,
    parameter int unsigned WB    = DEF_WB,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    rgb2gray_stream_if.slave  bus
);

    localparam int unsigned SUM_W  = sum_width(PIX_W, WR, WG, WB);
    localparam int unsigned RSUM_W = SUM_W + 1;
    localparam int unsigned FRAME  = ROWS * COLS;
    localparam int unsigned CNT_W  = clog2(FRAME + 1);
    localparam int unsigned COL_W  = clog2(COLS + 1);
    localparam int unsigned ROW_W  = clog2(ROWS + 1);
`ifdef GRAY_ROUND_EN
    localparam int unsigned RND    = (2 ** SHIFT) / 2;
`else
    localparam int unsigned RND    = 0;
`endif
    localparam logic [PIX_W-1:0] GRAY_MAX = '1;

    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_nxt;
    logic [ROW_W-1:0]   row_q;
    logic [ROW_W-1:0]   row_nxt;
    logic               en;
    logic               accept;
    logic               out_acc;
    logic               start_go;
    logic               s1_vld;
    logic [SUM_W-1:0]   s1_sum;
    logic [RSUM_W-1:0]  rsum;
    logic [RSUM_W-1:0]  shifted;
    logic [PIX_W-1:0]   gray_c;

    // Handshake qualifiers; both stages move together when the output is free
    assign en          = !bus.m_valid | bus.m_ready;
    assign bus.s_ready = en & (state_q == RUN) & (in_cnt_q < CNT_W'(FRAME));
    assign accept      = bus.s_valid & bus.s_ready;
    assign out_acc     = bus.m_valid & bus.m_ready;
    assign start_go    = start & (state_q != RUN);

    // Next-state logic: a frame ends when its last output beat is taken
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start)                 state_nxt = RUN;
            RUN:     if (out_acc && bus.m_eof)  state_nxt = DONE;
            DONE:    if (start)                 state_nxt = RUN;
            default:                            state_nxt = IDLE;
        endcase
    end

    // State register and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done    <= (state_nxt == DONE);
        end
    end

    // Output position after this cycle's accepted beat (if any)
    always_comb begin
        col_nxt = col_q;
        row_nxt = row_q;
        if (out_acc) begin
            if (col_q == COL_W'(COLS - 1)) begin
                col_nxt = '0;
                row_nxt = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_nxt = col_q + COL_W'(1);
            end
        end
    end

    // Input and output position counters, cleared when a new frame is armed
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else if (start_go) begin
            in_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            if (accept) in_cnt_q <= in_cnt_q + CNT_W'(1);
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

    rgb2gray_wsum #(
        .PIX_W (PIX_W),
        .WR    (WR),
        .WG    (WG),
        .WB    (WB),
        .SUM_W (SUM_W)
    ) u_wsum (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .in_vld (accept),
        .red    (bus.s_red),
        .green  (bus.s_green),
        .blue   (bus.s_blue),
        .sum_q  (s1_sum),
        .vld_q  (s1_vld)
    );

    // Stage 2 combinational: optional rounding, shift, saturate
    always_comb begin
        rsum    = RSUM_W'(s1_sum) + RSUM_W'(RND);
        shifted = rsum >> SHIFT;
        gray_c  = (shifted > RSUM_W'(GRAY_MAX)) ? GRAY_MAX : PIX_W'(shifted);
    end

    // Stage 2 output register; frame flags refer to the beat being loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_gray  <= '0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
        end else if (en) begin
            bus.m_valid <= s1_vld;
            bus.m_gray  <= gray_c;
            bus.m_eol   <= s1_vld & (col_nxt == COL_W'(COLS - 1));
            bus.m_eof   <= s1_vld & (col_nxt == COL_W'(COLS - 1))
                                  & (row_nxt == ROW_W'(ROWS - 1));
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Self-checking bench for rgb2gray_stream (honours GRAY_ROUND_EN).
`timescale 1ns/1ps
module tb_rgb2gray_stream;

    localparam int unsigned PW = 8;
    localparam int unsigned R  = 2;
    localparam int unsigned C  = 3;
    localparam int unsigned FR = R * C;
`ifdef GRAY_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] gray;
    } vec_t;

    typedef struct {
        logic [7:0] gray;
        logic       eol;
        logic       eof;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, done, start2, done2;

    always #5 clk = ~clk;

    rgb2gray_stream_if #(.PIX_W(PW)) bus ();
    rgb2gray_stream_if #(.PIX_W(PW)) bus2 ();

    rgb2gray_stream #(
        .PIX_W(PW), .ROWS(R), .COLS(C), .WR(2), .WG(5), .WB(1), .SHIFT(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .bus(bus)
    );

    rgb2gray_stream #(
        .PIX_W(PW), .ROWS(1), .COLS(2), .WR(4), .WG(4), .WB(4), .SHIFT(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .done(done2), .bus(bus2)
    );

    exp_t       sb[$];
    exp_t       e_pop;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         in_idx = 0;
    int         n_in = 0;
    logic [7:0] drv_exp;
    bit         lat_chk = 1'b0;
    bit         stall_q = 1'b0;
    bit         done_chk = 1'b0;
    logic [7:0] hold_gray;
    logic       hold_eol, hold_eof;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input int r, input int g, input int b,
                                         input int wr, input int wg, input int wb,
                                         input int sh);
        int s;
        s = wr * r + wg * g + wb * b;
        if (RND && sh > 0) s = s + (1 << (sh - 1));
        s = s >> sh;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic [7:0] e);
        bus.s_red   = r;
        bus.s_green = g;
        bus.s_blue  = b;
        drv_exp     = e;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard monitor: push on input accept, pop/compare on output accept
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_q  = 1'b0;
            done_chk = 1'b0;
        end else begin
            if (done_chk) begin
                chk("done_after_eof", 32'(done), 32'd1);
                done_chk = 1'b0;
            end
            if (stall_q) begin
                chk("stall_valid", 32'(bus.m_valid), 32'd1);
                chk("stall_gray", 32'(bus.m_gray), 32'(hold_gray));
                chk("stall_flags", 32'({bus.m_eol, bus.m_eof}), 32'({hold_eol, hold_eof}));
            end
            if (bus.s_valid && bus.s_ready) begin
                sb.push_back('{drv_exp, (in_idx % C) == (C - 1), in_idx == (FR - 1), cyc});
                in_idx++;
                n_in++;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    chk("gray", 32'(bus.m_gray), 32'(e_pop.gray));
                    chk("eol", 32'(bus.m_eol), 32'(e_pop.eol));
                    chk("eof", 32'(bus.m_eof), 32'(e_pop.eof));
                    if (lat_chk) chk("latency", 32'(cyc - e_pop.cyc), 32'd2);
                    if (e_pop.eof) begin
                        chk("done_low_at_eof", 32'(done), 32'd0);
                        done_chk = 1'b1;
                    end
                end
            end
            stall_q   = bus.m_valid && !bus.m_ready;
            hold_gray = bus.m_gray;
            hold_eol  = bus.m_eol;
            hold_eof  = bus.m_eof;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[FR];
        int   k;
        bit   acc;
        int   got;
        int   n2;
        logic [7:0] sat_exp[2];

        tbl[0] = '{8'd100, 8'd50,  8'd20,  RND ? 8'd59 : 8'd58};
        tbl[1] = '{8'd255, 8'd255, 8'd255, 8'd255};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd0};
        tbl[3] = '{8'd3,   8'd0,   8'd0,   RND ? 8'd1 : 8'd0};
        tbl[4] = '{8'd10,  8'd20,  8'd30,  RND ? 8'd19 : 8'd18};
        tbl[5] = '{8'd0,   8'd1,   8'd0,   RND ? 8'd1 : 8'd0};
        sat_exp[0] = 8'd255;
        sat_exp[1] = 8'd30;

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        bus.s_valid = 1'b1; bus.m_ready = 1'b0;
        set_px(8'd0, 8'd0, 8'd0, 8'd0);
        bus2.s_valid = 1'b0; bus2.m_ready = 1'b0;
        bus2.s_red = '0; bus2.s_green = '0; bus2.s_blue = '0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_gray", 32'(bus.m_gray), 32'd0);
        chk("rst_flags", 32'({bus.m_eol, bus.m_eof}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_s_ready", 32'(bus.s_ready), 32'd0);
        tick();

        // Frame 1: table vectors, continuous valid, no stall, then a 7th pixel
        in_idx = 0; n_in = 0; lat_chk = 1'b1; bus.m_ready = 1'b1;
        bus.s_valid = 1'b0;
        pulse_start();
        bus.s_valid = 1'b1;
        set_px(tbl[0].r, tbl[0].g, tbl[0].b, tbl[0].gray);
        k = 0;
        for (int i = 0; i < 20 && k < int'(FR); i++) begin
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            tick();
            if (acc) k++;
            if (k < int'(FR)) set_px(tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].gray);
            else              set_px(8'd1, 8'd2, 8'd3, model(1, 2, 3, 2, 5, 1, 3));
        end
        chk("frame1_inputs_taken", 32'(k), 32'(FR));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s_ready_after_frame", 32'(bus.s_ready), 32'd0);
            tick();
        end
        for (int i = 0; i < 20 && !done; i++) tick();
        @(negedge clk);
        chk("frame1_done", 32'(done), 32'd1);
        chk("frame1_accepted", 32'(n_in), 32'(FR));
        chk("frame1_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        bus.s_valid = 1'b0;

        // Frame 2: rerun from DONE with random valid and random stalls
        lat_chk = 1'b0; in_idx = 0; n_in = 0;
        pulse_start();
        @(negedge clk);
        chk("rerun_done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < 600 && !done; i++) begin
            logic [7:0] r8, g8, b8;
            r8 = 8'($urandom_range(0, 255));
            g8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.m_ready = ($urandom_range(0, 1) != 0);
            set_px(r8, g8, b8, model(int'(r8), int'(g8), int'(b8), 2, 5, 1, 3));
            tick();
        end
        bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        @(negedge clk);
        chk("frame2_done", 32'(done), 32'd1);
        chk("frame2_accepted", 32'(n_in), 32'(FR));
        chk("frame2_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Frame 3: reset while an output beat is stalled
        in_idx = 0;
        pulse_start();
        bus.m_ready = 1'b0; bus.s_valid = 1'b1;
        set_px(8'd100, 8'd50, 8'd20, tbl[0].gray);
        for (int i = 0; i < 10 && !bus.m_valid; i++) tick();
        chk("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
        rst = 1'b1; bus.m_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        in_idx = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_s_ready", 32'(bus.s_ready), 32'd0);
            tick();
        end
        pulse_start();
        @(negedge clk);
        chk("restart_s_ready", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
        repeat (4) tick();
        chk("frame3_sb_empty", 32'(sb.size()), 32'd0);

        // Saturation instance: weights 4/4/4, shift 2
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bus2.m_ready = 1'b1; bus2.s_valid = 1'b1;
        bus2.s_red = 8'd255; bus2.s_green = 8'd255; bus2.s_blue = 8'd255;
        got = 0; n2 = 0;
        for (int i = 0; i < 30 && got < 2; i++) begin
            @(negedge clk);
            acc = bus2.s_valid && bus2.s_ready;
            if (bus2.m_valid && bus2.m_ready) begin
                chk("sat_gray", 32'(bus2.m_gray), 32'(sat_exp[got]));
                chk("sat_eof", 32'(bus2.m_eof), 32'(got == 1));
                got++;
            end
            tick();
            if (acc) begin
                n2++;
                if (n2 == 1) begin
                    bus2.s_red = 8'd10; bus2.s_green = 8'd10; bus2.s_blue = 8'd10;
                end else begin
                    bus2.s_valid = 1'b0;
                end
            end
        end
        chk("sat_count", 32'(got), 32'd2);
        @(negedge clk);
        chk("sat_done", 32'(done2), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
